// File: rtl/arkanoid_spinner_decoder.sv
// arkanoid_spinner_decoder: synchronised, glitch-filtered AB spinner decoder
// with a wrapping position count, a saturating read-and-clear delta and a sticky illegal-transition flag.
module arkanoid_spinner_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_12m,
  input  logic             reset,
  input  logic             cen,
  input  logic [1:0]       spinner,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [7:0]       delta_out,
  output logic             err_out,
  output logic [CNT_W-1:0] position,
  output logic             step_up,
  output logic             step_dn
);
  localparam logic [3:0] L_FLT = 4'(FILTER_LEN);
  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]        r_prev, r_state, r_old;
  logic [3:0]        r_cnt;
  logic              r_acc_v, r_err;
  logic signed [7:0] r_acc;
  logic [1:0]        w_sync;
  logic [3:0]        w_cnt_nxt, w_tr;
  logic              w_accept, w_up, w_dn, w_bad;
  logic signed [7:0] w_step, w_acc_sat;
  always_comb begin
    w_sync    = r_sync[SYNC_STAGES-1];
    w_cnt_nxt = (w_sync == r_prev) ? r_cnt + 4'd1 : 4'd1;
    w_accept  = cen && (w_sync != r_state) && (w_cnt_nxt == L_FLT);
    w_tr      = {r_old, r_state};
    w_up      = r_acc_v && (w_tr inside {4'b0010, 4'b1011, 4'b1101, 4'b0100});
    w_dn      = r_acc_v && (w_tr inside {4'b0001, 4'b0111, 4'b1110, 4'b1000});
    w_bad     = r_acc_v && (&(r_old ^ r_state));
    w_step    = w_up ? 8'sd1 : w_dn ? -8'sd1 : 8'sd0;
    w_acc_sat = (w_up && r_acc != 8'sh7f) ? r_acc + 8'sd1 :
                (w_dn && r_acc != 8'sh80) ? r_acc - 8'sd1 : r_acc;
  end
  // Accept registers the old/new pair; the step is decoded one clock later.
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      r_sync  <= '1;
      r_prev  <= 2'b11;
      r_state <= 2'b11;
      r_old   <= 2'b11;
      r_cnt   <= '0;
      r_acc_v <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], spinner};
      r_acc_v <= w_accept;
      if (cen) begin
        r_prev <= w_sync;
        r_cnt  <= (w_sync == r_state || w_accept) ? 4'd0 : w_cnt_nxt;
      end
      if (w_accept) begin
        r_old   <= r_state;
        r_state <= w_sync;
      end
    end
  end
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      position  <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      r_acc     <= '0;
      r_err     <= 1'b0;
      delta_out <= '0;
      err_out   <= 1'b0;
      rd_ack    <= 1'b0;
    end else begin
      step_up  <= w_up;
      step_dn  <= w_dn;
      position <= position + {{(CNT_W-1){w_dn}}, w_up | w_dn};
      rd_ack   <= rd_req;
      if (rd_req) begin
        delta_out <= r_acc;
        err_out   <= r_err;
        r_acc     <= w_step;
        r_err     <= w_bad;
      end else begin
        r_acc <= w_acc_sat;
        r_err <= r_err | w_bad;
      end
    end
  end
endmodule

// File: tb/tb_arkanoid_spinner_decoder.sv
// tb_arkanoid_spinner_decoder: directed bench for the spinner decoder at default parameters.
module tb_arkanoid_spinner_decoder;
  logic       clk_12m = 1'b0, reset = 1'b0, cen = 1'b1, rd_req = 1'b0;
  logic [1:0] spinner = 2'b11;
  logic       rd_ack, err_out, step_up, step_dn;
  logic [7:0] delta_out, position;
  int total = 0, bad = 0;
  int n_up = 0, n_dn = 0, n_both = 0;
  int u0, d0;
  logic [1:0] dec_seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
  logic [1:0] inc_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  arkanoid_spinner_decoder dut (
    .clk_12m(clk_12m), .reset(reset), .cen(cen), .spinner(spinner), .rd_req(rd_req),
    .rd_ack(rd_ack), .delta_out(delta_out), .err_out(err_out), .position(position),
    .step_up(step_up), .step_dn(step_dn)
  );

  always #5 clk_12m = ~clk_12m;

  always @(negedge clk_12m) begin
    if (step_up) n_up++;
    if (step_dn) n_dn++;
    if (step_up && step_dn) n_both++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12m);
    #1;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    spinner = v;
    repeat (n) tick();
  endtask

  task automatic rd(input string tag, input int d, input int e);
    int dv;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    dv = $signed(delta_out);
    chk({tag, "_ack"}, int'(rd_ack), 1);
    chk({tag, "_delta"}, dv, d);
    chk({tag, "_err"}, int'(err_out), e);
    tick();
    chk({tag, "_ack_low"}, int'(rd_ack), 0);
  endtask

  initial begin
    // reset held low while the spinner moves
    hold(2'b01, 3); hold(2'b00, 3); hold(2'b10, 3); hold(2'b11, 3);
    chk("rst_pos", int'(position), 0);
    chk("rst_delta", int'(delta_out), 0);
    chk("rst_flags", int'({rd_ack, err_out, step_up, step_dn}), 0);
    chk("rst_steps", n_up + n_dn, 0);
    reset = 1'b1;
    hold(2'b11, 10);
    chk("idle_steps", n_up + n_dn, 0);
    // cen low freezes the filter
    cen = 1'b0;
    hold(2'b01, 20);
    hold(2'b11, 2);
    cen = 1'b1;
    hold(2'b11, 8);
    chk("cen_off_pos", int'(position), 0);
    // increment with latency check on the first step
    u0 = n_up;
    hold(2'b01, 6);
    chk("lat_early", int'(step_up), 0);
    tick();
    chk("lat_step", int'(step_up), 1);
    chk("lat_pos", int'(position), 1);
    tick();
    chk("lat_width", int'(step_up), 0);
    hold(2'b01, 6);
    hold(2'b00, 8); hold(2'b10, 8); hold(2'b11, 8);
    chk("inc_ups", n_up - u0, 4);
    chk("inc_pos", int'(position), 4);
    rd("rd_inc", 4, 0);
    // glitch reject, then a just-long-enough pulse
    u0 = n_up; d0 = n_dn;
    hold(2'b01, 3); hold(2'b11, 8);
    chk("glitch_steps", (n_up - u0) + (n_dn - d0), 0);
    chk("glitch_pos", int'(position), 4);
    hold(2'b01, 4); hold(2'b01, 4);
    chk("edge_ups", n_up - u0, 1);
    chk("edge_pos", int'(position), 5);
    hold(2'b00, 8); hold(2'b10, 8); hold(2'b11, 8);
    rd("rd_glitch", 4, 0);
    // illegal double-bit change
    u0 = n_up; d0 = n_dn;
    hold(2'b00, 8);
    chk("ill_steps", (n_up - u0) + (n_dn - d0), 0);
    chk("ill_pos", int'(position), 8);
    rd("rd_ill", 0, 1);
    rd("rd_ill2", 0, 0);
    hold(2'b10, 8); hold(2'b11, 8);
    chk("pre_rst_pos", int'(position), 10);
    // async reset drops the pending ack
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("pre_rst_ack", int'(rd_ack), 1);
    chk("pre_rst_delta", int'(delta_out), 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_ack", int'(rd_ack), 0);
    chk("mid_rst_pos", int'(position), 0);
    chk("mid_rst_delta", int'(delta_out), 0);
    tick(); tick();
    reset = 1'b1;
    hold(2'b11, 10);
    // saturation and wrap
    d0 = n_dn;
    for (int i = 0; i < 130; i++) hold(dec_seq[i % 4], 8);
    chk("sat_dns", n_dn - d0, 130);
    chk("wrap_dn_pos", int'(position), 126);
    rd("rd_sat_neg", -128, 0);
    u0 = n_up;
    for (int i = 0; i < 256; i++) hold(inc_seq[i % 4], 8);
    chk("sat_ups", n_up - u0, 256);
    chk("wrap_up_pos", int'(position), 126);
    rd("rd_sat_pos", 127, 0);
    // read colliding with a step
    for (int i = 0; i < 5; i++) hold(inc_seq[i % 4], 8);
    hold(2'b11, 6);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("col_step", int'(step_up), 1);
    chk("col_ack", int'(rd_ack), 1);
    chk("col_delta", int'($signed(delta_out)), 5);
    chk("col_pos", int'(position), 132);
    tick();
    chk("col_ack_low", int'(rd_ack), 0);
    hold(2'b11, 8);
    rd("rd_col_next", 1, 0);
    rd("rd_b2b", 0, 0);
    chk("never_both", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
